// File: rtl/frame_arbiter.sv
// frame_arbiter: round-robin, frame-granular arbiter for the input buffer's single enqueue port.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   tracing                          enables new grants; sampled only between frames
//   req_valid/req_eof/req_vector     per-producer beat valid, last-beat flag, beat data
//   req_ready                        per-producer accept (combinational)
//   ib_ready                         input buffer can take a beat this cycle
//   enqueue/eof_out/vector_out       registered beat towards the input buffer
//   grant_id, busy, trunc_count      current/last grant, frame in progress, forced-eof count
module frame_arbiter #(
  parameter int N = 8,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ = 4,
  parameter int MAX_FRAME_LEN = 256,
  localparam int GW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_FRAME_LEN),
  localparam int BW = N * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tracing,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_eof,
  input  logic [NUM_REQ*BW-1:0] req_vector,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  ib_ready,
  output logic                  enqueue,
  output logic                  eof_out,
  output logic [BW-1:0]         vector_out,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic [15:0]           trunc_count
);
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] grant_id_q, grant_id_d, last_grant_q, last_grant_d, pick, idx;
  logic [CW-1:0] beat_cnt_q, beat_cnt_d;
  logic [BW-1:0] vector_out_q, vector_out_d, cur_vec;
  logic [15:0] trunc_count_q, trunc_count_d;
  logic enqueue_q, enqueue_d, eof_out_q, eof_out_d;
  logic pick_found, grant, accept, forced, cur_eof, last_beat;
  // Round-robin scan starting just above the previous winner.
  always_comb begin
    pick = last_grant_q;
    idx = last_grant_q;
    pick_found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = GW'((int'(last_grant_q) + i) % NUM_REQ);
      if (!pick_found && req_valid[idx]) begin
        pick = idx;
        pick_found = 1'b1;
      end
    end
  end
  assign cur_vec   = req_vector[grant_id_q*BW +: BW];
  assign cur_eof   = req_eof[grant_id_q];
  assign grant     = (state_q == IDLE) & tracing & pick_found;
  assign accept    = (state_q == LOCKED) & req_valid[grant_id_q] & ib_ready;
  // A frame that reaches its length limit without eof is cut here.
  assign forced    = (beat_cnt_q == CW'(MAX_FRAME_LEN - 1)) & ~cur_eof;
  assign last_beat = accept & (cur_eof | forced);
  always_comb begin
    req_ready = '0;
    req_ready[grant_id_q] = (state_q == LOCKED) & ib_ready;
  end
  always_comb begin
    state_d       = grant ? LOCKED : last_beat ? IDLE : state_q;
    grant_id_d    = grant ? pick : grant_id_q;
    last_grant_d  = grant ? pick : last_grant_q;
    beat_cnt_d    = grant ? '0 : accept ? beat_cnt_q + 1'b1 : beat_cnt_q;
    enqueue_d     = accept;
    vector_out_d  = accept ? cur_vec : vector_out_q;
    eof_out_d     = accept ? (cur_eof | forced) : eof_out_q;
    trunc_count_d = (accept & forced & ~&trunc_count_q) ? trunc_count_q + 16'd1 : trunc_count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      grant_id_q    <= '0;
      last_grant_q  <= GW'(NUM_REQ - 1);
      beat_cnt_q    <= '0;
      enqueue_q     <= 1'b0;
      eof_out_q     <= 1'b0;
      vector_out_q  <= '0;
      trunc_count_q <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      beat_cnt_q    <= beat_cnt_d;
      enqueue_q     <= enqueue_d;
      eof_out_q     <= eof_out_d;
      vector_out_q  <= vector_out_d;
      trunc_count_q <= trunc_count_d;
    end
  end
  assign enqueue     = enqueue_q;
  assign eof_out     = eof_out_q;
  assign vector_out  = vector_out_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q == LOCKED);
  assign trunc_count = trunc_count_q;
endmodule

// File: tb/tb_frame_arbiter.sv
// tb_frame_arbiter: randomized scoreboard bench for frame_arbiter against a frame-level reference model.
module tb_frame_arbiter;
  localparam int NR = 4;
  localparam int NL = 2;
  localparam int DW = 16;
  localparam int MFL = 4;
  localparam int BW = NL * DW;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tracing = 1'b0;
  logic ib_ready = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR-1:0] req_eof = '0;
  logic [NR*BW-1:0] req_vector = '0;
  logic [NR-1:0] req_ready;
  logic enqueue, eof_out, busy;
  logic [BW-1:0] vector_out;
  logic [1:0] grant_id;
  logic [15:0] trunc_count;
  int nvec = 0;
  int nerr = 0;
  logic [BW:0] pq[NR][$];
  logic [BW:0] exq[$];
  logic [NR-1:0] vld;
  int owner, last, gid, cnt, tc;
  bit exp_enq;

  frame_arbiter #(.N(NL), .DATA_WIDTH(DW), .NUM_REQ(NR), .MAX_FRAME_LEN(MFL)) dut (
    .clk(clk), .rst_n(rst_n), .tracing(tracing), .req_valid(req_valid), .req_eof(req_eof),
    .req_vector(req_vector), .req_ready(req_ready), .ib_ready(ib_ready), .enqueue(enqueue),
    .eof_out(eof_out), .vector_out(vector_out), .grant_id(grant_id), .busy(busy),
    .trunc_count(trunc_count)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    last = NR - 1;
    gid = 0;
    cnt = 0;
    tc = 0;
    exp_enq = 0;
    vld = '0;
    exq.delete();
    for (int r = 0; r < NR; r++) pq[r].delete();
  endtask

  task automatic gen_frame(int r);
    int len;
    logic [BW-1:0] d;
    len = $urandom_range(1, 6);
    for (int i = 0; i < len; i++) begin
      d = BW'($urandom);
      pq[r].push_back({(i == len - 1) ? 1'b1 : 1'b0, d});
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_enqueue"}, enqueue, 0);
    chk({tag, "_eof_out"}, eof_out, 0);
    chk({tag, "_vector_out"}, vector_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_trunc_count"}, trunc_count, 0);
  endtask

  // mode 0: random traffic and tracing; mode 1: no new frames, tracing held high
  task automatic step(int mode);
    logic [BW:0] b;
    logic [NR-1:0] er;
    bit forced, found;
    int r;
    @(negedge clk);
    for (int k = 0; k < NR; k++) begin
      if (mode == 0 && pq[k].size() == 0 && $urandom_range(0, 5) == 0) gen_frame(k);
      if (!vld[k] && pq[k].size() > 0 && $urandom_range(0, 3) != 0) vld[k] = 1'b1;
      req_eof[k] = vld[k] ? pq[k][0][BW] : 1'($urandom);
      req_vector[k*BW +: BW] = vld[k] ? pq[k][0][BW-1:0] : BW'($urandom);
    end
    req_valid = vld;
    tracing = (mode == 0) ? ($urandom_range(0, 9) != 0) : 1'b1;
    ib_ready = ($urandom_range(0, 3) != 0);
    #1;
    er = '0;
    if (owner >= 0) er[owner] = ib_ready;
    chk("enqueue", enqueue, exp_enq);
    chk("busy", busy, owner >= 0);
    chk("grant_id", grant_id, gid);
    chk("trunc_count", trunc_count, tc);
    chk("req_ready", req_ready, er);
    exp_enq = 0;
    if (owner < 0) begin
      found = 0;
      if (tracing)
        for (int i = 1; i <= NR; i++) begin
          r = (last + i) % NR;
          if (!found && vld[r]) begin
            found = 1;
            owner = r;
            last = r;
            gid = r;
            cnt = 0;
          end
        end
    end else if (vld[owner] && ib_ready) begin
      b = pq[owner].pop_front();
      forced = (cnt == MFL - 1) && !b[BW];
      exq.push_back({b[BW] | forced, b[BW-1:0]});
      exp_enq = 1;
      vld[owner] = 1'b0;
      cnt++;
      if (b[BW] || forced) begin
        if (forced && tc < 65535) tc++;
        owner = -1;
      end
    end
  endtask

  always @(negedge clk) begin
    logic [BW:0] e;
    if (rst_n && enqueue) begin
      if (exq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_beat: got data %0h eof %0b, expected no beat", vector_out, eof_out);
      end else begin
        e = exq.pop_front();
        chk("beat_data", vector_out, e[BW-1:0]);
        chk("beat_eof", eof_out, e[BW]);
      end
    end
  end

  initial begin
    int k;
    model_reset();
    #3;
    check_zero("reset");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3000) step(0);
    k = 0;
    while (!(owner >= 0 && cnt == 1) && k < 2000) begin
      step(0);
      k++;
    end
    if (k == 2000) begin
      nvec++;
      nerr++;
      $display("FAIL mid_frame_search: got timeout, expected a frame at beat 2");
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = '0;
    tracing = 1'b0;
    #1;
    check_zero("async_reset");
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;
    gen_frame(0);
    gen_frame(3);
    vld = 4'b1001;
    step(1);
    step(1);
    chk("tie_grant", grant_id, 0);
    chk("tie_busy", busy, 1);
    repeat (1000) step(0);
    k = 0;
    while ((owner >= 0 || pq[0].size() + pq[1].size() + pq[2].size() + pq[3].size() > 0) && k < 3000) begin
      step(1);
      k++;
    end
    if (k == 3000) begin
      nvec++;
      nerr++;
      $display("FAIL drain: got timeout, expected all frames delivered");
    end
    repeat (3) step(1);
    chk("scoreboard_empty", exq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
